sw_evt_trig_master: RTL and testbench
=====================================

# sw_evt_trig_master

Bus initiator that converts local software-event trigger requests (from an accelerator, DMA or HW sequencer) into single-word writes on an XBAR_PERIPH_BUS master port targeting the cluster software-event trigger slave. Requests are buffered in a small FIFO and issued one at a time, waiting for grant and response before the next. It sits beside the event unit on the cluster peripheral interconnect, on the initiator side of the trigger slave.

## Interface
- NB_CORES, 4: cores addressable by a trigger mask; 1..32.
- NB_SW_EVT, 8: software event lines; power of two, max 8.
- FIFO_DEPTH, 4: trigger queue entries; power of two, ≥2.
- BASE_ADDR, 32'h0000_0000: byte address of event 0 in the trigger slave; bits [4:0] zero.

- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- trig_valid_i  in  1  trigger request valid.
- trig_ready_o  out  1  queue can accept (not full, or coalesce hit).
- trig_evt_id_i  in  $clog2(NB_SW_EVT)  event index.
- trig_core_mask_i  in  NB_CORES  target cores; all-zero = broadcast to all cores.
- trig_done_o  out  1  one-cycle pulse when a write's response (r_valid) returns.
- busy_o  out  1  FSM not IDLE or FIFO non-empty.
- periph_int_bus_master  XBAR_PERIPH_BUS.Master  write initiator port.

## Operation
- Handshake: trigger accepted on cycle with trig_valid_i & trig_ready_o; inputs sampled that edge.
- Bus write drive: add = BASE_ADDR + (evt_id << 2); we_n = 0; be = 4'hF; wdata = zero-extended mask; id = '0.
- FSM states: IDLE, REQ, RESP.
  - IDLE: FIFO non-empty → pop head into request register, → REQ.
  - REQ: req = 1, address/data stable from request register; gnt → RESP; no gnt → hold.
  - RESP: req = 0; r_valid → trig_done_o = 1, → IDLE. r_rdata/r_opc ignored.
- Only one transaction outstanding; r_valid outside RESP ignored.
- FIFO full and no coalesce hit → trig_ready_o = 0; no drop.
- Push and pop in the same cycle allowed, including when full (pop frees the slot only next cycle; trig_ready_o stays 0 that cycle).
- Reset mid-transaction: req deasserts asynchronously, FIFO emptied, FSM → IDLE; late gnt/r_valid after reset ignored.
- Reset values: req 0, we_n 1, add 0, wdata 0, be 0, id 0, trig_ready_o 1, trig_done_o 0, busy_o 0.

## Timing
- Trigger accepted at edge N into an empty, idle block: pop at N+1; req high during cycle N+1→N+2; slave grants same cycle → RESP; r_valid in the following cycle → trig_done_o pulse; back in IDLE two edges after req rises.
- Minimum 3 cycles per queued trigger at full rate with a zero-wait slave.
- trig_ready_o, busy_o registered-state derived, no comb path from periph_int_bus_master inputs to trig_ready_o.

## Configuration
- Macro SW_EVT_TRIG_COALESCE_EN.
- Defined: an accepted trigger whose evt_id equals the FIFO tail entry (FIFO non-empty, tail not being popped that cycle) is merged: tail mask |= new mask; if either mask is zero the merged mask is zero (broadcast). No push; trig_ready_o = 1 on coalesce hit even when full.
- Undefined: every accepted trigger pushes its own entry; trig_ready_o = !full.

## Structure
- Package sw_evt_trig_pkg: sw_evt_trig_entry_t struct (evt_id, core_mask), state enum (IDLE/REQ/RESP), EVT_ADDR_STRIDE = 4.
- Sub-module sw_evt_trig_fifo: synchronous FIFO with tail read/modify port for coalescing; top holds FSM and bus drive.

## Test plan
- Single trigger evt 3, mask 4'b0101, BASE 0 → one write add 0x0C, wdata 0x5, be 0xF; trig_done_o one pulse; busy_o low afterwards.
- Five triggers back-to-back, distinct ids, depth 4 → trig_ready_o low exactly while full; five writes in order.
- Slave holds gnt low 6 cycles → req, add, wdata stable throughout; single write issued.
- Coalesce on: evt 2 mask 0x1 then evt 2 mask 0x8 while first in flight then evt 2 mask 0x2 → second merged with third to 0xA; total two writes; off → three writes.
- Coalesce on: evt 1 mask 0x3 then evt 1 mask 0x0 queued → single write wdata 0x0.
- Reset asserted during REQ with 2 queued → req drops immediately, no further writes, busy_o 0 after release.

Source files
------------

// File: rtl/sw_evt_trig_pkg.sv
// Shared types, constants and helpers for the software-event trigger master.
package sw_evt_trig_pkg;

    localparam int unsigned EVT_ID_MAX_W    = 3;
    localparam int unsigned CORE_MASK_MAX_W = 32;
    localparam logic [31:0] EVT_ADDR_STRIDE = 32'd4;

    typedef struct packed {
        logic [EVT_ID_MAX_W-1:0]    evt_id;
        logic [CORE_MASK_MAX_W-1:0] core_mask;
    } sw_evt_trig_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } sw_evt_trig_state_e;

    // An all-zero mask means broadcast, so it absorbs any other mask.
    function automatic logic [CORE_MASK_MAX_W-1:0] merge_core_mask(
        input logic [CORE_MASK_MAX_W-1:0] a,
        input logic [CORE_MASK_MAX_W-1:0] b
    );
        if (a == '0 || b == '0) return '0;
        return a | b;
    endfunction

endpackage

// File: rtl/sw_evt_trig_master_if.sv
// Cluster peripheral interconnect bus (XBAR_PERIPH_BUS) with initiator/target modports.
interface XBAR_PERIPH_BUS #(
    parameter int unsigned ID_WIDTH = 5
);
    logic                req;
    logic [31:0]         add;
    logic                we_n;
    logic [31:0]         wdata;
    logic [3:0]          be;
    logic                gnt;
    logic [ID_WIDTH-1:0] id;
    logic                r_valid;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_rdata;

    modport Master (
        output req, add, we_n, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );

    modport Slave (
        input  req, add, we_n, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface

// File: rtl/sw_evt_trig_fifo.sv
// Synchronous trigger queue with an extra tail read/modify port used for coalescing.
module sw_evt_trig_fifo
    import sw_evt_trig_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  sw_evt_trig_entry_t         push_data_i,
    input  logic                       pop_i,
    output sw_evt_trig_entry_t         head_o,
    output sw_evt_trig_entry_t         tail_o,
    input  logic                       tail_wr_i,
    input  sw_evt_trig_entry_t         tail_wdata_i,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sw_evt_trig_entry_t mem_q [DEPTH];
    sw_evt_trig_entry_t mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   tail_ptr;

    assign tail_ptr = wr_ptr_q - 1'b1;
    assign head_o   = mem_q[rd_ptr_q];
    assign tail_o   = mem_q[tail_ptr];
    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign count_o  = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (tail_wr_i) mem_d[tail_ptr] = tail_wdata_i;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/sw_evt_trig_master.sv
// Turns queued software-event trigger requests into single-word writes on the peripheral bus.
// Optional tail coalescing of same-event triggers: define SW_EVT_TRIG_COALESCE_EN.
module sw_evt_trig_master
    import sw_evt_trig_pkg::*;
#(
    parameter int unsigned NB_CORES   = 4,
    parameter int unsigned NB_SW_EVT  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         trig_valid_i,
    output logic                         trig_ready_o,
    input  logic [$clog2(NB_SW_EVT)-1:0] trig_evt_id_i,
    input  logic [NB_CORES-1:0]          trig_core_mask_i,
    output logic                         trig_done_o,
    output logic                         busy_o,
    XBAR_PERIPH_BUS.Master               periph_int_bus_master
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    sw_evt_trig_entry_t push_entry, fifo_head, fifo_tail, tail_wdata;
    logic               fifo_push, fifo_pop, fifo_empty, fifo_full, tail_wr;
    logic               coal_hit, accept;
    logic [CNT_W-1:0]   fifo_count;

    sw_evt_trig_state_e state_q, state_d;
    logic               req_q, req_d;
    logic               we_n_q, we_n_d;
    logic [31:0]        add_q, add_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               done_q, done_d;

    sw_evt_trig_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (fifo_push),
        .push_data_i  (push_entry),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .tail_o       (fifo_tail),
        .tail_wr_i    (tail_wr),
        .tail_wdata_i (tail_wdata),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .count_o      (fifo_count)
    );

    always_comb begin
        push_entry.evt_id    = EVT_ID_MAX_W'(trig_evt_id_i);
        push_entry.core_mask = CORE_MASK_MAX_W'(trig_core_mask_i);
`ifdef SW_EVT_TRIG_COALESCE_EN
        // The tail is off-limits when it is the single entry being popped this cycle.
        coal_hit = !fifo_empty && !(fifo_pop && fifo_count == CNT_W'(1))
                   && (fifo_tail.evt_id == push_entry.evt_id);
        tail_wdata           = fifo_tail;
        tail_wdata.core_mask = merge_core_mask(fifo_tail.core_mask, push_entry.core_mask);
`else
        coal_hit   = 1'b0;
        tail_wdata = '0;
`endif
        trig_ready_o = !fifo_full || coal_hit;
        accept       = trig_valid_i && trig_ready_o;
        fifo_push    = accept && !coal_hit;
        tail_wr      = accept && coal_hit;
    end

`ifndef SW_EVT_TRIG_COALESCE_EN
    logic unused_coal;
    assign unused_coal = ^{fifo_tail, fifo_count};
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_n_d   = we_n_q;
        add_d    = add_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                req_d    = 1'b1;
                we_n_d   = 1'b0;
                be_d     = 4'hF;
                add_d    = BASE_ADDR + 32'(fifo_head.evt_id) * EVT_ADDR_STRIDE;
                wdata_d  = 32'(fifo_head.core_mask);
                state_d  = REQ;
            end
            REQ: if (periph_int_bus_master.gnt) begin
                req_d   = 1'b0;
                state_d = RESP;
            end
            RESP: if (periph_int_bus_master.r_valid) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_n_q  <= 1'b1;
            add_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_n_q  <= we_n_d;
            add_q   <= add_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
        end
    end

    assign periph_int_bus_master.req   = req_q;
    assign periph_int_bus_master.we_n  = we_n_q;
    assign periph_int_bus_master.add   = add_q;
    assign periph_int_bus_master.wdata = wdata_q;
    assign periph_int_bus_master.be    = be_q;
    assign periph_int_bus_master.id    = '0;

    assign trig_done_o = done_q;
    assign busy_o      = (state_q != IDLE) || !fifo_empty;

    logic unused_rsp;
    assign unused_rsp = ^{periph_int_bus_master.r_opc, periph_int_bus_master.r_id,
                          periph_int_bus_master.r_rdata};
endmodule

// File: tb/tb_sw_evt_trig_master.sv
// Directed bench for sw_evt_trig_master with a simple zero/programmable-wait bus target.
module tb_sw_evt_trig_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig_valid = 1'b0;
    logic       trig_ready;
    logic [2:0] trig_evt_id = '0;
    logic [3:0] trig_core_mask = '0;
    logic       trig_done;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    XBAR_PERIPH_BUS #(.ID_WIDTH(5)) bus ();

    sw_evt_trig_master #(
        .NB_CORES   (4),
        .NB_SW_EVT  (8),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .trig_valid_i          (trig_valid),
        .trig_ready_o          (trig_ready),
        .trig_evt_id_i         (trig_evt_id),
        .trig_core_mask_i      (trig_core_mask),
        .trig_done_o           (trig_done),
        .busy_o                (busy),
        .periph_int_bus_master (bus)
    );

    always #5 clk = ~clk;

    // Bus target: grants after gnt_wait cycles of req, answers r_valid the cycle after.
    int unsigned gnt_wait = 0;
    int unsigned hold = 0;
    logic        slave_en = 1'b1;
    logic [31:0] wr_add[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_be[$];
    int unsigned done_cnt = 0;

    initial begin
        bus.gnt = 1'b0;
        bus.r_valid = 1'b0;
        bus.r_opc = 1'b0;
        bus.r_id = '0;
        bus.r_rdata = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.gnt = 1'b0;
            bus.r_valid = 1'b0;
            hold = 0;
        end else if (slave_en) begin
            bus.r_valid = bus.gnt;
            if (bus.gnt) begin
                bus.gnt = 1'b0;
            end else if (bus.req) begin
                if (hold >= gnt_wait) begin
                    bus.gnt = 1'b1;
                    hold = 0;
                    if (bus.we_n == 1'b0) begin
                        wr_add.push_back(bus.add);
                        wr_data.push_back(bus.wdata);
                        wr_be.push_back(bus.be);
                    end
                end else begin
                    hold++;
                end
            end
        end
    end

    always @(negedge clk) if (rst_n && trig_done) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_add.delete();
        wr_data.delete();
        wr_be.delete();
        done_cnt = 0;
    endtask

    task automatic send(input logic [2:0] id, input logic [3:0] mask);
        int unsigned waited = 0;
        @(negedge clk);
        trig_valid = 1'b1;
        trig_evt_id = id;
        trig_core_mask = mask;
        #1;
        while (!trig_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!trig_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_accept evt %0d: ready=%b required=1", id, trig_ready);
            trig_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            trig_valid = 1'b0;
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && bus.req !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_writes(input int unsigned n);
        for (int i = 0; i < 300 && wr_add.size() < n; i++) @(negedge clk);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (bus.req !== 1'b0)      begin n_err++; $display("FAIL rst_req: got %b want 0", bus.req); end
        n_cmp++; if (bus.we_n !== 1'b1)     begin n_err++; $display("FAIL rst_we_n: got %b want 1", bus.we_n); end
        n_cmp++; if (bus.add !== 32'h0)     begin n_err++; $display("FAIL rst_add: got %h want 0", bus.add); end
        n_cmp++; if (bus.wdata !== 32'h0)   begin n_err++; $display("FAIL rst_wdata: got %h want 0", bus.wdata); end
        n_cmp++; if (bus.be !== 4'h0)       begin n_err++; $display("FAIL rst_be: got %h want 0", bus.be); end
        n_cmp++; if (bus.id !== 5'h0)       begin n_err++; $display("FAIL rst_id: got %h want 0", bus.id); end
        n_cmp++; if (trig_ready !== 1'b1)   begin n_err++; $display("FAIL rst_ready: got %b want 1", trig_ready); end
        n_cmp++; if (trig_done !== 1'b0)    begin n_err++; $display("FAIL rst_done: got %b want 0", trig_done); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        clear_log();
        gnt_wait = 0;
        send(3'd3, 4'b0101);
        n_cmp++; if (busy !== 1'b1)    begin n_err++; $display("FAIL single_busy_queued: got %b want 1", busy); end
        n_cmp++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL single_req_early: got %b want 0", bus.req); end
        @(posedge clk); #1;
        n_cmp++; if (bus.req !== 1'b1)        begin n_err++; $display("FAIL single_req: got %b want 1", bus.req); end
        n_cmp++; if (bus.add !== 32'h0000_000C) begin n_err++; $display("FAIL single_add: got %h want 0000000c", bus.add); end
        n_cmp++; if (bus.wdata !== 32'h5)     begin n_err++; $display("FAIL single_wdata: got %h want 5", bus.wdata); end
        n_cmp++; if (bus.be !== 4'hF)         begin n_err++; $display("FAIL single_be: got %h want f", bus.be); end
        n_cmp++; if (bus.we_n !== 1'b0)       begin n_err++; $display("FAIL single_we_n: got %b want 0", bus.we_n); end
        @(posedge clk); #1;
        n_cmp++; if (bus.req !== 1'b0)   begin n_err++; $display("FAIL single_req_after_gnt: got %b want 0", bus.req); end
        @(posedge clk); #1;
        n_cmp++; if (trig_done !== 1'b1) begin n_err++; $display("FAIL single_done_pulse: got %b want 1", trig_done); end
        @(posedge clk); #1;
        n_cmp++; if (trig_done !== 1'b0) begin n_err++; $display("FAIL single_done_end: got %b want 0", trig_done); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
        wait_writes(1);
        n_cmp++; if (wr_add.size() != 1) begin n_err++; $display("FAIL single_nwrites: got %0d want 1", wr_add.size()); end
        n_cmp++; if (done_cnt != 1)      begin n_err++; $display("FAIL single_ndone: got %0d want 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] masks [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
        logic       rdy   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int unsigned i;
        clear_log();
        gnt_wait = 1000;
        for (i = 0; i < 5; i++) begin
            send(3'(i), masks[i]);
            n_cmp++;
            if (trig_ready !== rdy[i]) begin
                n_err++; $display("FAIL b2b_ready_after_%0d: got %b want %b", i, trig_ready, rdy[i]);
            end
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (trig_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full_hold: got %b want 0", trig_ready); end
        n_cmp++; if (done_cnt != 0)       begin n_err++; $display("FAIL b2b_done_while_stalled: got %0d want 0", done_cnt); end
        gnt_wait = 0;
        for (int k = 0; k < 50 && trig_ready !== 1'b1; k++) begin
            @(negedge clk); #1;
        end
        n_cmp++; if (trig_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_reopen: got %b want 1", trig_ready); end
        n_cmp++; if (done_cnt != 1)       begin n_err++; $display("FAIL b2b_ready_reopen_done: got %0d want 1", done_cnt); end
        wait_writes(5);
        n_cmp++; if (wr_add.size() != 5) begin n_err++; $display("FAIL b2b_nwrites: got %0d want 5", wr_add.size()); end
        for (int k = 0; k < 5 && k < wr_add.size(); k++) begin
            n_cmp++;
            if (wr_add[k] !== 32'(k * 4) || wr_data[k] !== 32'(masks[k]) || wr_be[k] !== 4'hF) begin
                n_err++;
                $display("FAIL b2b_write_%0d: got add=%h data=%h be=%h want add=%h data=%h be=f",
                         k, wr_add[k], wr_data[k], wr_be[k], 32'(k * 4), 32'(masks[k]));
            end
        end
    endtask

    task automatic test_gnt_wait();
        logic [31:0] a0, d0;
        int unsigned hi;
        logic        stable;
        clear_log();
        gnt_wait = 6;
        send(3'd5, 4'hA);
        wait_req();
        a0 = bus.add;
        d0 = bus.wdata;
        hi = (bus.req === 1'b1) ? 1 : 0;
        stable = 1'b1;
        for (int i = 0; i < 40 && bus.req === 1'b1; i++) begin
            @(negedge clk); #1;
            if (bus.req === 1'b1) begin
                hi++;
                if (bus.add !== a0 || bus.wdata !== d0) stable = 1'b0;
            end
        end
        n_cmp++; if (a0 !== 32'h14 || d0 !== 32'hA) begin n_err++; $display("FAIL gw_payload: got add=%h data=%h want add=00000014 data=0000000a", a0, d0); end
        n_cmp++; if (hi != 7)       begin n_err++; $display("FAIL gw_req_cycles: got %0d want 7", hi); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL gw_stable: got %b want 1", stable); end
        wait_writes(1);
        n_cmp++; if (wr_add.size() != 1) begin n_err++; $display("FAIL gw_nwrites: got %0d want 1", wr_add.size()); end
        gnt_wait = 0;
    endtask

    task automatic test_coalesce();
`ifdef SW_EVT_TRIG_COALESCE_EN
        localparam int unsigned NEXP = 2;
        logic [31:0] exp_d [NEXP] = '{32'h1, 32'hA};
`else
        localparam int unsigned NEXP = 3;
        logic [31:0] exp_d [NEXP] = '{32'h1, 32'h8, 32'h2};
`endif
        clear_log();
        gnt_wait = 5;
        send(3'd2, 4'h1);
        wait_req();
        send(3'd2, 4'h8);
        send(3'd2, 4'h2);
        wait_writes(NEXP);
        n_cmp++; if (wr_add.size() != NEXP) begin n_err++; $display("FAIL coal_nwrites: got %0d want %0d", wr_add.size(), NEXP); end
        for (int k = 0; k < NEXP && k < wr_add.size(); k++) begin
            n_cmp++;
            if (wr_add[k] !== 32'h8 || wr_data[k] !== exp_d[k]) begin
                n_err++;
                $display("FAIL coal_write_%0d: got add=%h data=%h want add=00000008 data=%h", k, wr_add[k], wr_data[k], exp_d[k]);
            end
        end
        gnt_wait = 0;
    endtask

    task automatic test_coalesce_bcast();
`ifdef SW_EVT_TRIG_COALESCE_EN
        localparam int unsigned NEXP = 2;
        logic [31:0] exp_a [NEXP] = '{32'h1C, 32'h4};
        logic [31:0] exp_d [NEXP] = '{32'h1, 32'h0};
`else
        localparam int unsigned NEXP = 3;
        logic [31:0] exp_a [NEXP] = '{32'h1C, 32'h4, 32'h4};
        logic [31:0] exp_d [NEXP] = '{32'h1, 32'h3, 32'h0};
`endif
        clear_log();
        gnt_wait = 5;
        send(3'd7, 4'h1);
        wait_req();
        send(3'd1, 4'h3);
        send(3'd1, 4'h0);
        wait_writes(NEXP);
        n_cmp++; if (wr_add.size() != NEXP) begin n_err++; $display("FAIL bcast_nwrites: got %0d want %0d", wr_add.size(), NEXP); end
        for (int k = 0; k < NEXP && k < wr_add.size(); k++) begin
            n_cmp++;
            if (wr_add[k] !== exp_a[k] || wr_data[k] !== exp_d[k]) begin
                n_err++;
                $display("FAIL bcast_write_%0d: got add=%h data=%h want add=%h data=%h", k, wr_add[k], wr_data[k], exp_a[k], exp_d[k]);
            end
        end
        gnt_wait = 0;
    endtask

    task automatic test_reset_mid();
        clear_log();
        gnt_wait = 1000;
        send(3'd0, 4'h1);
        wait_req();
        send(3'd1, 4'h2);
        send(3'd2, 4'h4);
        @(negedge clk);
        #2;
        n_cmp++; if (bus.req !== 1'b1) begin n_err++; $display("FAIL rm_req_before: got %b want 1", bus.req); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL rm_req_async: got %b want 0", bus.req); end
        repeat (2) @(negedge clk);
        clear_log();
        gnt_wait = 0;
        #2;
        rst_n = 1'b1;
        slave_en = 1'b0;
        @(negedge clk); #1;
        bus.gnt = 1'b1;
        bus.r_valid = 1'b1;
        @(negedge clk); #1;
        bus.gnt = 1'b0;
        bus.r_valid = 1'b0;
        slave_en = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++; if (wr_add.size() != 0) begin n_err++; $display("FAIL rm_nwrites: got %0d want 0", wr_add.size()); end
        n_cmp++; if (done_cnt != 0)      begin n_err++; $display("FAIL rm_ndone: got %0d want 0", done_cnt); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_cmp++; if (bus.req !== 1'b0)   begin n_err++; $display("FAIL rm_req_after: got %b want 0", bus.req); end
        n_cmp++; if (trig_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", trig_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gnt_wait();
        test_coalesce();
        test_coalesce_bcast();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
